// File: rtl/apb_reg_bank.sv
// apb_reg_bank - parametrised APB slave register bank.
//
// NUM_REGS registers of APB_DATA_WIDTH bits, register i at byte offset
// i*(APB_DATA_WIDTH/8) inside a 256-byte window at REG_BASE. Every bit is
// RW, RO or W1C, selected by RW_MASK / W1C_MASK (W1C wins over RW).
// Transfers pass IDLE -> [WAIT] -> RESP. PREADY, PRDATA and PSLVERR are
// registered. Writes commit on the edge that ends RESP.
//
// Optional build macro: APB_WSTRB_EN adds apb_strb_in (byte-lane write
// strobes, latched with the setup data).
//
// Ports:
//   apb_clk_in, apb_rst_in        clock, synchronous active-high reset
//   apb_addr_in .. apb_wdata_in   APB request (PADDR/PSEL/PENABLE/PWRITE/PWDATA)
//   apb_strb_in                   byte strobes (APB_WSTRB_EN only)
//   apb_rdata_out/ready/slverr    APB response, registered
//   reg_q_out                     stored RW/W1C bits, RO positions read 0
//   ro_data_in                    live values for RO bits
//   w1c_set_in                    hardware set for W1C bits
//   wr_pulse_out / rd_pulse_out   one-cycle pulses per register after access
module apb_reg_bank #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] REG_BASE = 32'ha0300000,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS*APB_DATA_WIDTH-1:0] RW_MASK   = '1,
    parameter logic [NUM_REGS*APB_DATA_WIDTH-1:0] W1C_MASK  = '0,
    parameter logic [NUM_REGS*APB_DATA_WIDTH-1:0] RESET_VAL = '0,
    parameter int WAIT_STATES = 0
) (
    input  logic                               apb_clk_in,
    input  logic                               apb_rst_in,
    input  logic [APB_ADDR_WIDTH-1:0]          apb_addr_in,
    input  logic                               apb_psel_in,
    input  logic                               apb_penable_in,
    input  logic                               apb_write_in,
    input  logic [APB_DATA_WIDTH-1:0]          apb_wdata_in,
`ifdef APB_WSTRB_EN
    input  logic [APB_DATA_WIDTH/8-1:0]        apb_strb_in,
`endif
    output logic [APB_DATA_WIDTH-1:0]          apb_rdata_out,
    output logic                               apb_ready_out,
    output logic                               apb_slverr_out,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q_out,
    input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] ro_data_in,
    input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] w1c_set_in,
    output logic [NUM_REGS-1:0]                wr_pulse_out,
    output logic [NUM_REGS-1:0]                rd_pulse_out
);
    localparam int DW      = APB_DATA_WIDTH;
    localparam int BYTES   = DW / 8;
    localparam int ALIGN_W = $clog2(BYTES);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int FLAT_W  = NUM_REGS * DW;
    localparam logic [FLAT_W-1:0] RW_EFF  = RW_MASK & ~W1C_MASK;
    localparam logic [FLAT_W-1:0] SW_MASK = RW_MASK | W1C_MASK;   // bits with storage
    localparam logic [8:0] WIN_BYTES  = 9'(NUM_REGS * BYTES);
    localparam logic [7:0] ALIGN_MASK = 8'(BYTES - 1);
    localparam logic [3:0] WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state_reg, w_state_next;
    logic [3:0]          r_cnt_reg, w_cnt_next;
    logic [IDX_W-1:0]    r_idx_reg;
    logic                r_write_reg, r_err_reg;
    logic [DW-1:0]       r_wdata_reg;
    logic [DW-1:0]       r_rdata_reg, w_rdata_next;
    logic                r_ready_reg, w_ready_next;
    logic                r_slverr_reg, w_slverr_next;
    logic [NUM_REGS-1:0] r_wr_pulse_reg, w_wr_pulse_next;
    logic [NUM_REGS-1:0] r_rd_pulse_reg, w_rd_pulse_next;
    logic [FLAT_W-1:0]   r_store_reg, w_store_next;

    logic [7:0]          w_off;
    logic                w_base_ok, w_range_ok, w_align_ok, w_dec_err;
    logic [IDX_W-1:0]    w_idx, w_cur_idx;
    logic                w_in_idle, w_cur_write, w_cur_err;
    logic [NUM_REGS-1:0] w_writable;
    logic                w_sel_writable;
    logic [DW-1:0]       w_sel_rdata;
    logic [FLAT_W-1:0]   w_read_all;
    logic                w_commit_ok, w_store_commit;
    logic [DW-1:0]       w_lane_mask;
    logic                w_strb_any;

    // ---------------- address decode of the live request ----------------
    assign w_off      = apb_addr_in[7:0];
    assign w_base_ok  = (apb_addr_in[APB_ADDR_WIDTH-1:8] == REG_BASE[APB_ADDR_WIDTH-1:8]);
    assign w_range_ok = ({1'b0, w_off} < WIN_BYTES);
    assign w_align_ok = ((w_off & ALIGN_MASK) == 8'd0);
    assign w_idx      = IDX_W'(w_off >> ALIGN_W);
    assign w_dec_err  = !w_base_ok || !w_range_ok || !w_align_ok
                     || (apb_write_in && !w_sel_writable);

    // In IDLE the request is still on the bus; later it comes from the latches.
    // This lets a zero-wait transfer load its response on the setup edge.
    assign w_in_idle   = (r_state_reg == S_IDLE);
    assign w_cur_idx   = w_in_idle ? w_idx : r_idx_reg;
    assign w_cur_write = w_in_idle ? apb_write_in : r_write_reg;
    assign w_cur_err   = w_in_idle ? (apb_penable_in || w_dec_err) : r_err_reg;

    assign w_read_all = r_store_reg | (ro_data_in & ~SW_MASK);

    always_comb begin
        w_sel_writable = 1'b0;
        w_sel_rdata    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i))
                w_sel_writable = w_writable[i];
            if (w_cur_idx == IDX_W'(i))
                w_sel_rdata = w_read_all[i*DW +: DW];
        end
    end

`ifdef APB_WSTRB_EN
    logic [BYTES-1:0] r_strb_reg;
    genvar gl;
    for (gl = 0; gl < BYTES; gl++) begin : g_lane
        assign w_lane_mask[gl*8 +: 8] = {8{r_strb_reg[gl]}};
    end
    assign w_strb_any = |r_strb_reg;
`else
    assign w_lane_mask = '1;
    assign w_strb_any  = 1'b1;
`endif

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state_reg;
        w_cnt_next   = r_cnt_reg;
        case (r_state_reg)
            S_IDLE: begin
                if (apb_psel_in) begin
                    if (apb_penable_in || WAIT_STATES == 0) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!apb_psel_in)
                    w_state_next = S_IDLE;     // master abandoned the transfer
                else if (r_cnt_reg == 4'd0)
                    w_state_next = S_RESP;
                else
                    w_cnt_next = r_cnt_reg - 4'd1;
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered on the next edge) ----------------
    assign w_commit_ok    = (r_state_reg == S_RESP) && apb_psel_in && apb_penable_in && !r_err_reg;
    assign w_store_commit = w_commit_ok && r_write_reg;

    always_comb begin
        w_ready_next    = (w_state_next == S_RESP);
        w_slverr_next   = w_ready_next && w_cur_err;
        w_rdata_next    = (w_ready_next && !w_cur_write && !w_cur_err) ? w_sel_rdata : '0;
        w_wr_pulse_next = '0;
        w_rd_pulse_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx_reg == IDX_W'(i)) begin
                w_wr_pulse_next[i] = w_store_commit && w_strb_any;
                w_rd_pulse_next[i] = w_commit_ok && !r_write_reg;
            end
        end
    end

    // ---------------- storage next value, per register ----------------
    genvar gi;
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [DW-1:0] RW_M  = RW_EFF[gi*DW +: DW];
        localparam logic [DW-1:0] W1C_M = W1C_MASK[gi*DW +: DW];
        logic [DW-1:0] w_cur, w_we, w_clr;
        assign w_cur = r_store_reg[gi*DW +: DW];
        assign w_we  = (w_store_commit && (r_idx_reg == IDX_W'(gi))) ? w_lane_mask : '0;
        assign w_clr = r_wdata_reg & w_we;
        // W1C: clear first, then OR in the hardware set so a set wins.
        assign w_store_next[gi*DW +: DW] =
              (RW_M  & ((w_cur & ~w_we) | w_clr))
            | (W1C_M & ((w_cur & ~w_clr) | w1c_set_in[gi*DW +: DW]));
        assign w_writable[gi] = |(RW_M | W1C_M);
    end

    // ---------------- FSM: state and data registers ----------------
    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            r_state_reg    <= S_IDLE;
            r_cnt_reg      <= '0;
            r_idx_reg      <= '0;
            r_write_reg    <= 1'b0;
            r_err_reg      <= 1'b0;
            r_wdata_reg    <= '0;
            r_rdata_reg    <= '0;
            r_ready_reg    <= 1'b0;
            r_slverr_reg   <= 1'b0;
            r_wr_pulse_reg <= '0;
            r_rd_pulse_reg <= '0;
            r_store_reg    <= RESET_VAL & SW_MASK;
`ifdef APB_WSTRB_EN
            r_strb_reg     <= '0;
`endif
        end else begin
            r_state_reg <= w_state_next;
            r_cnt_reg   <= w_cnt_next;
            if (w_in_idle && apb_psel_in) begin
                r_idx_reg   <= w_idx;
                r_write_reg <= apb_write_in;
                r_err_reg   <= w_cur_err;
                r_wdata_reg <= apb_wdata_in;
`ifdef APB_WSTRB_EN
                r_strb_reg  <= apb_strb_in;
`endif
            end
            r_rdata_reg    <= w_rdata_next;
            r_ready_reg    <= w_ready_next;
            r_slverr_reg   <= w_slverr_next;
            r_wr_pulse_reg <= w_wr_pulse_next;
            r_rd_pulse_reg <= w_rd_pulse_next;
            r_store_reg    <= w_store_next;
        end
    end

    assign apb_rdata_out  = r_rdata_reg;
    assign apb_ready_out  = r_ready_reg;
    assign apb_slverr_out = r_slverr_reg;
    assign reg_q_out      = r_store_reg;
    assign wr_pulse_out   = r_wr_pulse_reg;
    assign rd_pulse_out   = r_rd_pulse_reg;

endmodule
